// File: rtl/pkg_cpu_typedefs.sv
// Shared types and defaults for the CPU memory arbiter: FSM states, request
// sources and the default starvation/timeout limits.
package pkg_cpu_typedefs;

  typedef enum logic [1:0] {
    IDLE,
    GNT_IF,
    GNT_LS,
    DONE
  } arb_state_t;

  typedef enum logic {
    SRC_IF,
    SRC_LS
  } arb_src_t;

  localparam int ARB_STARVE_MAX = 4;
  localparam int ARB_TIMEOUT    = 16;

  // Bits needed to hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/cpu_arb_timeout_cnt.sv
// Up-counter with synchronous clear and enable; flags expiry once the count
// reaches LIMIT-1 and holds there until cleared.
module cpu_arb_timeout_cnt #(
  parameter int LIMIT = 16,
  parameter int W     = $clog2(LIMIT) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expired
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_count <= '0;
    end else if (i_en && !o_expired) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_expired = (r_count == W'(LIMIT - 1));

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Single-outstanding arbiter sharing one memory port between the fetch (IF)
// and load/store (LS) stages; LS has priority, bounded by an IF starvation guard.
module cpu_mem_arbiter
  import pkg_cpu_typedefs::*;
#(
  parameter int AW         = 32,
  parameter int DW         = 32,
  parameter int STARVE_MAX = ARB_STARVE_MAX,
  parameter int TIMEOUT    = ARB_TIMEOUT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  input  logic          ls_req,
  input  logic          ls_we,
  input  logic [AW-1:0] ls_addr,
  input  logic [DW-1:0] ls_wdata,
  output logic          ls_ack,
  output logic [DW-1:0] ls_rdata,
  output logic          bus_err,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata
);

  localparam int SW = (cnt_width(STARVE_MAX) < 3) ? 3 : cnt_width(STARVE_MAX);

  arb_state_t    r_state;
  arb_state_t    w_state_nxt;
  arb_src_t      r_src;
  logic [AW-1:0] r_addr;
  logic          r_we;
  logic [DW-1:0] r_wdata;
  logic [DW-1:0] r_rdata;
  logic          r_err;
  logic [SW-1:0] r_starve_cnt;

  logic w_in_gnt;
  logic w_in_done;
  logic w_expired;
  logic w_pick_ls;
  logic w_pick_if;
  logic w_starved;

  assign w_in_gnt  = (r_state == GNT_IF) || (r_state == GNT_LS);
  assign w_in_done = (r_state == DONE);
  assign w_starved = if_req && (r_starve_cnt == SW'(STARVE_MAX));
  assign w_pick_ls = ls_req && !w_starved;
  assign w_pick_if = if_req && !w_pick_ls;

  cpu_arb_timeout_cnt #(
    .LIMIT(TIMEOUT)
  ) u_timeout (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (!w_in_gnt),
    .i_en     (w_in_gnt),
    .o_expired(w_expired)
  );

  always_comb begin
    // NOTE: default first so no branch leaves the next state unassigned (no latch).
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_pick_ls) begin
          w_state_nxt = GNT_LS;
        end else if (w_pick_if) begin
          w_state_nxt = GNT_IF;
        end
      end
      GNT_IF, GNT_LS: begin
        if (mem_ack || w_expired) begin
          w_state_nxt = DONE;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: non-blocking so every register updates from pre-edge values.
    if (rst) begin
      r_state      <= IDLE;
      r_src        <= SRC_IF;
      r_addr       <= '0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE) begin
        if (w_pick_ls) begin
          r_src   <= SRC_LS;
          r_addr  <= ls_addr;
          r_we    <= ls_we;
          r_wdata <= ls_wdata;
          // Only LS wins that leave a waiting fetch behind count toward starvation.
          if (!if_req) begin
            r_starve_cnt <= '0;
          end else if (r_starve_cnt != SW'(STARVE_MAX)) begin
            r_starve_cnt <= r_starve_cnt + 1'b1;
          end
        end else if (w_pick_if) begin
          r_src        <= SRC_IF;
          r_addr       <= if_addr;
          r_we         <= 1'b0;
          r_wdata      <= '0;
          r_starve_cnt <= '0;
        end
      end
      // Refreshed every grant cycle; the value captured on the exit edge is what DONE reports.
      if (w_in_gnt) begin
        r_rdata <= mem_ack ? mem_rdata : '0;
        r_err   <= !mem_ack;
      end
    end
  end

  assign mem_req   = w_in_gnt;
  assign mem_we    = w_in_gnt && r_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_ack   = w_in_done && (r_src == SRC_IF);
  assign ls_ack   = w_in_done && (r_src == SRC_LS);
  assign if_rdata = if_ack ? r_rdata : '0;
  assign ls_rdata = ls_ack ? r_rdata : '0;
  assign bus_err  = w_in_done && r_err;

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares the single-port unified memory between the pipelined CPU's fetch stage (IF) and load/store stage (LS).
- Registered arbitration FSM; one outstanding memory transaction at a time.
- LS has fixed priority over IF, with an anti-starvation override and a memory-response timeout that returns a bus error.
- Its acks drive the pipeline stall logic: a stage stalls while its req is high and its ack has not yet arrived.

Parameters:
- AW, 32, address width in bits.
- DW, 32, data width in bits.
- STARVE_MAX, 4, number of consecutive LS grants made while IF is pending, after which IF wins the next arbitration.
- TIMEOUT, 16, maximum cycles a granted transaction waits for mem_ack before it is terminated with an error.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- if_req  in  1  fetch request; held high until if_ack.
- if_addr  in  AW  fetch address.
- if_ack  out  1  one-cycle pulse; fetch transaction complete.
- if_rdata  out  DW  fetch data; valid only while if_ack is high.
- ls_req  in  1  load/store request; held high until ls_ack.
- ls_we  in  1  1 = store, 0 = load.
- ls_addr  in  AW  load/store address.
- ls_wdata  in  DW  store data.
- ls_ack  out  1  one-cycle pulse; load/store transaction complete.
- ls_rdata  out  DW  load data; valid only while ls_ack is high.
- bus_err  out  1  one-cycle pulse together with if_ack or ls_ack when the transaction timed out.
- mem_req  out  1  memory request; held high until mem_ack or timeout.
- mem_we  out  1  memory write enable.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_ack  in  1  memory completion pulse; mem_rdata valid in the same cycle.
- mem_rdata  in  DW  memory read data.

Behaviour:
- Reset: rst high at any clock edge forces state IDLE and clears every output and counter to 0.
  - Applies mid-transaction: mem_req drops on the next cycle, and a late mem_ack is ignored.
- States: IDLE, GNT_IF, GNT_LS, DONE.
- IDLE:
  - ls_req && !(if_req && starve_cnt==STARVE_MAX) -> GNT_LS.
  - else if_req -> GNT_IF.
  - else stay in IDLE.
  - The winner's address/we/wdata are captured into registers on the transition edge.
- GNT_x:
  - mem_req=1 with the registered mem_addr/mem_we/mem_wdata, held stable for the whole state.
  - mem_we is forced to 0 for IF.
  - mem_ack=1 -> DONE. The read data is latched and x_ack, x_rdata are driven in the DONE cycle.
  - Timeout counter increments every GNT cycle. When it reaches TIMEOUT-1 without mem_ack -> DONE with bus_err=1 and x_rdata=0.
  - mem_ack arriving in that same final cycle wins: normal completion, no error.
- DONE:
  - Exactly one cycle: x_ack=1 for the granted source, mem_req=0.
  - Always -> IDLE; no same-cycle regrant.
- Latency: with memory latency L (mem_ack L cycles after mem_req rises), ack arrives L+2 cycles after req is sampled in IDLE. Throughput is one access per L+3 cycles.
- Starvation counter (3 bits min, saturating):
  - Increments on each IDLE->GNT_LS transition while if_req=1.
  - Clears on IDLE->GNT_IF, and on any IDLE->GNT_LS made while if_req=0.
- Requester deassertion mid-transaction is a protocol violation: the transaction still completes and the ack is still pulsed. The bench flags it as an error; the RTL has no special handling.
- Simultaneous if_req and ls_req with starve_cnt<STARVE_MAX: LS wins, and IF stalls.
- The acks are mutually exclusive, never both high.
- mem_ack while not in a GNT state is ignored.
- Timeout counter width is clog2(TIMEOUT)+1; it clears on entry to every GNT state.

Decomposition:
- Add to pkg_cpu_typedefs:
  - arb_state_t enum {IDLE, GNT_IF, GNT_LS, DONE}.
  - arb_src_t enum {SRC_IF, SRC_LS}.
  - Default constants ARB_STARVE_MAX=4 and ARB_TIMEOUT=16.
- One sub-module, cpu_arb_timeout_cnt: a parameterized up-counter with sync clear/enable and an expired flag. It is instantiated once for the timeout; the starvation counter stays inline.

Test Plan:
- Single fetch: if_req=1, addr=0x100, memory L=2 returning 0xDEADBEEF -> mem_req for 3 cycles, mem_addr=0x100, mem_we=0; if_ack one cycle, if_rdata=0xDEADBEEF, 4 cycles after req sampled.
- Store: ls_req=1, ls_we=1, addr=0x200, wdata=0x12345678, L=1 -> mem_we=1, mem_wdata=0x12345678; ls_ack pulse, bus_err=0, if_ack never set.
- Contention/starvation: if_req and ls_req both held high for 6 transactions, STARVE_MAX=4 -> grant order LS,LS,LS,LS,IF,LS; starve_cnt returns to 0 after the IF grant.
- Timeout: ls_req=1, load, memory never acks, TIMEOUT=16 -> mem_req high exactly 16 cycles, then ls_ack=1, bus_err=1, ls_rdata=0; IDLE next cycle.
- Ack at the timeout boundary: mem_ack in the 16th GNT cycle with rdata=0xA5A5A5A5 -> normal ack, bus_err=0, rdata=0xA5A5A5A5.
- Reset mid-transaction: rst=1 during GNT_IF, then a late mem_ack -> mem_req=0 the next cycle, no if_ack, state IDLE; a new ls_req is granted normally afterwards.
